vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Upstream timing stage for the VGA output path. Divides CLK into a pixel-enable strobe
//   and drives VGA_CLK. Runs horizontal and vertical phase FSMs with counters and generates
//   HS/VS, active-video, line/frame markers and one-pixel-lookahead request coordinates.
//   The downstream colour stage registers R/G/B on PIX_EN so colour lines up with HS/VS.
// PARAMETERS
//   CLK_DIV   2    CLK cycles per pixel (>=2); 50 MHz CLK -> 25 MHz pixel
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   horizontal sync width (pixels)
//   H_BP      48   horizontal back porch (pixels); H_TOTAL=sum=800, must be <=1024
//   V_ACTIVE  480  visible lines
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vertical sync width (lines)
//   V_BP      33   vertical back porch (lines); V_TOTAL=sum=525, must be <=1024
//   HS_POL    0    asserted level of HS (0 = active-low)
//   VS_POL    0    asserted level of VS
// PORTS
//   CLK          in   1   system clock; all logic on rising edge
//   RST_N        in   1   asynchronous active-low reset
//   VGA_CLK      out  1   pixel clock to DAC; registered, low first half of pixel period, high second half
//   PIX_EN       out  1   one-CLK strobe, last CLK of each pixel period
//   H_CNT        out  10  current pixel column, 0..H_TOTAL-1
//   V_CNT        out  10  current line, 0..V_TOTAL-1
//   ACTIVE       out  1   current pixel is inside H_ACTIVE x V_ACTIVE
//   HS           out  1   horizontal sync, =HS_POL during H sync phase, else ~HS_POL
//   VS           out  1   vertical sync, =VS_POL during V sync phase, else ~VS_POL
//   LINE_START   out  1   high for whole pixel period while H_CNT==0
//   FRAME_START  out  1   high for whole pixel period while H_CNT==0 and V_CNT==0
//   REQ_X        out  10  column of the pixel displayed after the next PIX_EN
//   REQ_Y        out  10  line of that pixel
//   REQ_VALID    out  1   that pixel is active video
// BEHAVIOUR
//   - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. PIX_EN=1 exactly when div_cnt==CLK_DIV-1.
//     VGA_CLK is registered from (next div_cnt >= CLK_DIV/2).
//   - All pixel-domain outputs update only on the CLK edge that ends a PIX_EN cycle.
//     They are computed from next-state values, so H_CNT/V_CNT/HS/VS/ACTIVE/markers/REQ_*
//     all change on the same edge. They are aligned to the same pixel with zero skew.
//   - H FSM: H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT. Transitions occur at
//     H_CNT = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and wrap H_TOTAL-1 -> 0.
//   - V FSM: same four phases on lines. It advances only on the H wrap (H_CNT H_TOTAL-1 -> 0).
//     V_CNT wraps V_TOTAL-1 -> 0, and the frame restarts.
//   - ACTIVE = (H state==H_ACT) && (V state==V_ACT). HS is derived from the H FSM only.
//     VS is derived from the V FSM only and changes on line boundaries (H_CNT==0).
//   - REQ_X/REQ_Y equal the (H_CNT,V_CNT) successor, including wrap.
//     REQ_VALID = ACTIVE of the successor.
//   - Reset (async assert, sync deassert on CLK): div_cnt=0, H_CNT=H_TOTAL-1, V_CNT=V_TOTAL-1,
//     H state=H_BP, V state=V_BP, VGA_CLK=0, PIX_EN=0, ACTIVE=0, HS=~HS_POL, VS=~VS_POL,
//     LINE_START=0, FRAME_START=0, REQ_X=0, REQ_Y=0, REQ_VALID=1.
//     The first PIX_EN after reset moves to (0,0) and raises FRAME_START.
//   - Reset mid-frame returns immediately to the reset values. There are no partial-line artefacts.
//   - Counters never exceed TOTAL-1. Out-of-range states recover to H_BP/V_BP on the next wrap.
// TESTING
//   1 Hold RST_N=0 for 5 CLK -> all outputs at reset values. Release -> first PIX_EN at CLK 2;
//     next edge gives H_CNT=0, V_CNT=0, ACTIVE=1, FRAME_START=1, LINE_START=1.
//   2 Run one line -> ACTIVE for H_CNT 0..639. HS=0 exactly for H_CNT 656..751 (96 pixels = 192 CLK).
//     H_CNT 799 -> 0 increments V_CNT.
//   3 Run one frame -> VS=0 exactly for V_CNT 490..491. ACTIVE never set for V_CNT>=480.
//     FRAME_START rising edges are 840000 CLK apart.
//   4 Lookahead check -> at every PIX_EN, REQ_X/REQ_Y equal H_CNT/V_CNT after the edge.
//     At (799,524), REQ=(0,0) and REQ_VALID=1.
//   5 Pulse RST_N low at (300,200) for 1 CLK -> outputs return to reset values.
//     The next frame starts cleanly with FRAME_START after 2 CLK.
//   6 CLK_DIV=4, HS_POL=1 -> PIX_EN every 4 CLK, VGA_CLK 2 low/2 high.
//     HS=1 for H_CNT 656..751 (384 CLK).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Timing stage for the VGA output path. A clock divider produces a one-cycle
//   pixel-enable strobe and a registered pixel clock for the DAC. Horizontal and
//   vertical phase FSMs with their counters produce sync, active-video and
//   line/frame markers. The block also produces the coordinates of the pixel that
//   will be on screen after the next pixel strobe, so the colour stage can fetch
//   one pixel ahead.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   vga_clk      out  pixel clock: low for the first half of a pixel period, high for the second
//   pix_en       out  one-clk strobe in the last clk of each pixel period
//   h_cnt        out  current pixel column, 0..H_TOTAL-1
//   v_cnt        out  current line, 0..V_TOTAL-1
//   active       out  current pixel lies in the visible area
//   hs / vs      out  horizontal / vertical sync; HS_POL / VS_POL is the asserted level
//   line_start   out  high for the whole pixel period of column 0
//   frame_start  out  high for the whole pixel period of pixel (0,0)
//   req_x/req_y  out  coordinates of the successor of (h_cnt, v_cnt)
//   req_valid    out  that successor pixel lies in the visible area

module vga_timing_gen #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       vga_clk,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] req_x,
    output logic [9:0] req_y,
    output logic       req_valid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT_LEN    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_LEN    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    // Phase encoding shared by the horizontal and vertical FSMs.
    localparam logic [1:0] ST_ACT  = 2'd0;
    localparam logic [1:0] ST_FP   = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_BP   = 2'd3;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [1:0]       h_state;
    logic [1:0]       v_state;
    logic [1:0]       h_state_next;
    logic [1:0]       v_state_next;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic [9:0]       req_x_next;
    logic [9:0]       req_y_next;
    logic             req_valid_next;

    // Divider: the strobe marks the last clk of a pixel period, so every pixel-domain
    // register updates on the edge that closes the period.
    always_comb begin
        div_next = (div_cnt >= DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    assign pix_en = (div_cnt == DIV_LAST);

    // The pixel clock is registered from the next divider value so it is glitch free
    // and rises exactly at the midpoint of the pixel period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            vga_clk <= (div_next >= DIV_HALF);
        end
    end

    // Horizontal counter and phase FSM. Using >= for the wrap means a corrupted
    // counter can never run past the end of the line.
    always_comb begin
        h_wrap       = (h_cnt >= H_LAST);
        h_next       = h_wrap ? '0 : h_cnt + 1'b1;
        h_state_next = h_state;
        case (h_state)
            ST_ACT:  if (h_next == H_ACT_LEN)    h_state_next = ST_FP;
            ST_FP:   if (h_next == H_SYNC_START) h_state_next = ST_SYNC;
            ST_SYNC: if (h_next == H_BP_START)   h_state_next = ST_BP;
            ST_BP:   if (h_wrap)                 h_state_next = ST_ACT;
            default:                             h_state_next = ST_BP;
        endcase
    end

    // Vertical counter and phase FSM, stepping only when the line wraps, so VS
    // and the vertical phase only ever change at column 0.
    always_comb begin
        v_next       = v_cnt;
        v_state_next = v_state;
        if (h_wrap) begin
            v_next = (v_cnt >= V_LAST) ? '0 : v_cnt + 1'b1;
            case (v_state)
                ST_ACT:  if (v_next == V_ACT_LEN)    v_state_next = ST_FP;
                ST_FP:   if (v_next == V_SYNC_START) v_state_next = ST_SYNC;
                ST_SYNC: if (v_next == V_BP_START)   v_state_next = ST_BP;
                ST_BP:   if (v_cnt >= V_LAST)        v_state_next = ST_ACT;
                default:                             v_state_next = ST_BP;
            endcase
        end
    end

    // Lookahead: the successor of the position we are about to move to, wrapping
    // across line and frame ends.
    always_comb begin
        req_x_next = (h_next >= H_LAST) ? '0 : h_next + 1'b1;
        req_y_next = v_next;
        if (h_next >= H_LAST) begin
            req_y_next = (v_next >= V_LAST) ? '0 : v_next + 1'b1;
        end
        req_valid_next = (req_x_next < H_ACT_LEN) && (req_y_next < V_ACT_LEN);
    end

    // Every pixel-domain output is registered from next-state values on the same
    // edge, so counters, syncs, markers and lookahead describe the same pixel.
    // Reset parks the timing on the last pixel of the frame so the first strobe
    // lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            h_state     <= ST_BP;
            v_state     <= ST_BP;
            active      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            req_valid   <= 1'b1;
        end else if (pix_en) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            h_state     <= h_state_next;
            v_state     <= v_state_next;
            active      <= (h_state_next == ST_ACT) && (v_state_next == ST_ACT);
            hs          <= (h_state_next == ST_SYNC) ? HS_POL : ~HS_POL;
            vs          <= (v_state_next == ST_SYNC) ? VS_POL : ~VS_POL;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
            req_x       <= req_x_next;
            req_y       <= req_y_next;
            req_valid   <= req_valid_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen. Three instances share one clock and reset:
//   dut0 uses the default 640x480 timing, dut1 a tiny 15x9 frame so whole frames
//   fit in a short run, and dut2 the default geometry with CLK_DIV=4 and
//   active-high HS. A model computes every output from the number of clk edges
//   since reset and is compared against all three instances each cycle; directed
//   checks pin individual hand-computed values.

module tb_vga_timing_gen;

    typedef struct packed {
        logic       vga_clk;
        logic       pix_en;
        logic [9:0] h_cnt;
        logic [9:0] v_cnt;
        logic       active;
        logic       hs;
        logic       vs;
        logic       line_start;
        logic       frame_start;
        logic [9:0] req_x;
        logic [9:0] req_y;
        logic       req_valid;
    } vga_out_t;

    logic clk;
    logic rst_n;
    int   check_count = 0;
    int   error_count = 0;
    longint edge_count = 0;

    logic       vga_clk_0, pix_en_0, active_0, hs_0, vs_0, ls_0, fs_0, rv_0;
    logic [9:0] h_0, v_0, rx_0, ry_0;
    logic       vga_clk_1, pix_en_1, active_1, hs_1, vs_1, ls_1, fs_1, rv_1;
    logic [9:0] h_1, v_1, rx_1, ry_1;
    logic       vga_clk_2, pix_en_2, active_2, hs_2, vs_2, ls_2, fs_2, rv_2;
    logic [9:0] h_2, v_2, rx_2, ry_2;

    vga_out_t got_0, got_1, got_2;

    assign got_0 = {vga_clk_0, pix_en_0, h_0, v_0, active_0, hs_0, vs_0, ls_0, fs_0, rx_0, ry_0, rv_0};
    assign got_1 = {vga_clk_1, pix_en_1, h_1, v_1, active_1, hs_1, vs_1, ls_1, fs_1, rx_1, ry_1, rv_1};
    assign got_2 = {vga_clk_2, pix_en_2, h_2, v_2, active_2, hs_2, vs_2, ls_2, fs_2, rx_2, ry_2, rv_2};

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk_0), .pix_en(pix_en_0),
        .h_cnt(h_0), .v_cnt(v_0), .active(active_0), .hs(hs_0), .vs(vs_0),
        .line_start(ls_0), .frame_start(fs_0), .req_x(rx_0), .req_y(ry_0),
        .req_valid(rv_0)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk_1), .pix_en(pix_en_1),
        .h_cnt(h_1), .v_cnt(v_1), .active(active_1), .hs(hs_1), .vs(vs_1),
        .line_start(ls_1), .frame_start(fs_1), .req_x(rx_1), .req_y(ry_1),
        .req_valid(rv_1)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .HS_POL(1'b1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk_2), .pix_en(pix_en_2),
        .h_cnt(h_2), .v_cnt(v_2), .active(active_2), .hs(hs_2), .vs(vs_2),
        .line_start(ls_2), .frame_start(fs_2), .req_x(rx_2), .req_y(ry_2),
        .req_valid(rv_2)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Elapsed clk edges since reset released; everything the model predicts follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_count <= 0;
        else        edge_count <= edge_count + 1;
    end

    // Model: after tt edges, tt/d pixel periods have closed. Zero periods means the
    // parked reset position (last pixel of the frame); otherwise period k shows
    // linear pixel k-1 of the raster, modulo the frame size.
    function automatic vga_out_t model_out(input longint tt, input int d,
                                           input int ha, input int hf, input int hsy, input int hb,
                                           input int va, input int vf, input int vsy, input int vb,
                                           input logic hp, input logic vp);
        vga_out_t r;
        int     ht;
        int     vt;
        longint total;
        longint periods;
        longint idx;
        longint nidx;
        int     phase;
        int     h, v, nh, nv;
        ht      = ha + hf + hsy + hb;
        vt      = va + vf + vsy + vb;
        total   = longint'(ht) * longint'(vt);
        periods = tt / d;
        phase   = int'(tt % d);
        idx     = (periods == 0) ? total - 1 : (periods - 1) % total;
        nidx    = (idx + 1) % total;
        h       = int'(idx % ht);
        v       = int'(idx / ht);
        nh      = int'(nidx % ht);
        nv      = int'(nidx / ht);
        r.vga_clk     = (phase >= d / 2);
        r.pix_en      = (phase == d - 1);
        r.h_cnt       = 10'(h);
        r.v_cnt       = 10'(v);
        r.active      = (h < ha) && (v < va);
        r.hs          = (h >= ha + hf && h < ha + hf + hsy) ? hp : ~hp;
        r.vs          = (v >= va + vf && v < va + vf + vsy) ? vp : ~vp;
        r.line_start  = (h == 0);
        r.frame_start = (h == 0) && (v == 0);
        r.req_x       = 10'(nh);
        r.req_y       = 10'(nv);
        r.req_valid   = (nh < ha) && (nv < va);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        check_count++;
        if (actual !== required) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst_val, input int cycles);
        rst_n = rst_val;
        repeat (cycles) wait_neg();
    endtask

    // Every cycle, all three instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checkOutput("model_dut0", 64'(got_0),
                        64'(model_out(edge_count, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)));
            checkOutput("model_dut1", 64'(got_1),
                        64'(model_out(edge_count, 2, 8, 2, 3, 2, 4, 1, 2, 2, 1'b0, 1'b0)));
            checkOutput("model_dut2", 64'(got_2),
                        64'(model_out(edge_count, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0)));
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        int hs_low_clk, hs_min, hs_max, act_clk, act_max;
        int hs2_hi_clk, hs2_min, hs2_max, pe2_cnt, vc2_cnt;
        int fs_rises, fs_first, fs_gap, vs_min, vs_max, bad_active, seen_last;
        int hv;
        logic fs_prev;
        logic [20:0] req_at_last;
        logic found;

        rst_n = 1'b1;
        #1;
        applyStimulus(1'b0, 5);

        // Reset values.
        checkOutput("reset_h_cnt", 64'(h_0), 64'd799);
        checkOutput("reset_v_cnt", 64'(v_0), 64'd524);
        checkOutput("reset_flags", 64'({vga_clk_0, pix_en_0, active_0, hs_0, vs_0, ls_0, fs_0}),
                    64'(7'b0001100));
        checkOutput("reset_req", 64'({rx_0, ry_0, rv_0}), 64'({10'd0, 10'd0, 1'b1}));
        checkOutput("reset_hs_pol1", 64'(hs_2), 64'd0);

        // Release: first strobe in the next cycle, then the move to (0,0).
        applyStimulus(1'b1, 1);
        checkOutput("first_pix_en", 64'({pix_en_0, vga_clk_0}), 64'(2'b11));
        checkOutput("first_pix_hold", 64'(h_0), 64'd799);
        wait_neg();
        checkOutput("first_pixel_pos", 64'({h_0, v_0}), 64'({10'd0, 10'd0}));
        checkOutput("first_pixel_flags", 64'({active_0, fs_0, ls_0, hs_0}), 64'(4'b1111));
        checkOutput("first_pixel_req", 64'({rx_0, ry_0, rv_0}), 64'({10'd1, 10'd0, 1'b1}));

        // One full default line on dut0.
        hs_low_clk = 0; hs_min = 1023; hs_max = 0; act_clk = 0; act_max = 0;
        for (int i = 0; i < 1600; i++) begin
            hv = int'(h_0);
            if (!hs_0) begin
                hs_low_clk++;
                if (hv < hs_min) hs_min = hv;
                if (hv > hs_max) hs_max = hv;
            end
            if (active_0) begin
                act_clk++;
                if (hv > act_max) act_max = hv;
            end
            wait_neg();
        end
        checkOutput("hs_low_clks", 64'(hs_low_clk), 64'd192);
        checkOutput("hs_low_first", 64'(hs_min), 64'd656);
        checkOutput("hs_low_last", 64'(hs_max), 64'd751);
        checkOutput("active_clks", 64'(act_clk), 64'd1280);
        checkOutput("active_last_col", 64'(act_max), 64'd639);
        checkOutput("line_wrap_pos", 64'({h_0, v_0}), 64'({10'd0, 10'd1}));
        checkOutput("line_wrap_markers", 64'({ls_0, fs_0}), 64'(2'b10));

        // dut2: CLK_DIV=4 with active-high HS, over one full line-length window.
        hs2_hi_clk = 0; hs2_min = 1023; hs2_max = 0; pe2_cnt = 0; vc2_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            hv = int'(h_2);
            if (hs_2) begin
                hs2_hi_clk++;
                if (hv < hs2_min) hs2_min = hv;
                if (hv > hs2_max) hs2_max = hv;
            end
            if (pix_en_2)  pe2_cnt++;
            if (vga_clk_2) vc2_cnt++;
            wait_neg();
        end
        checkOutput("div4_hs_hi_clks", 64'(hs2_hi_clk), 64'd384);
        checkOutput("div4_hs_first", 64'(hs2_min), 64'd656);
        checkOutput("div4_hs_last", 64'(hs2_max), 64'd751);
        checkOutput("div4_pix_en_cnt", 64'(pe2_cnt), 64'd800);
        checkOutput("div4_vga_clk_hi", 64'(vc2_cnt), 64'd1600);

        // dut1 small frame (15x9 pixels = 270 clk).
        fs_rises = 0; fs_first = 0; fs_gap = 0; vs_min = 1023; vs_max = 0;
        bad_active = 0; seen_last = 0; req_at_last = '0;
        fs_prev = fs_1;
        for (int i = 0; i < 600; i++) begin
            if (fs_1 && !fs_prev) begin
                if (fs_rises == 0) fs_first = i;
                else if (fs_rises == 1) fs_gap = i - fs_first;
                fs_rises++;
            end
            fs_prev = fs_1;
            hv = int'(v_1);
            if (!vs_1) begin
                if (hv < vs_min) vs_min = hv;
                if (hv > vs_max) vs_max = hv;
            end
            if (active_1 && hv >= 4) bad_active++;
            if (h_1 == 10'd14 && v_1 == 10'd8) begin
                seen_last   = 1;
                req_at_last = {rx_1, ry_1, rv_1};
            end
            wait_neg();
        end
        checkOutput("frame_start_gap", 64'(fs_gap), 64'd270);
        checkOutput("vs_low_first", 64'(vs_min), 64'd5);
        checkOutput("vs_low_last", 64'(vs_max), 64'd6);
        checkOutput("active_in_vblank", 64'(bad_active), 64'd0);
        checkOutput("saw_last_pixel", 64'(seen_last), 64'd1);
        checkOutput("req_at_last_pixel", 64'(req_at_last), 64'({10'd0, 10'd0, 1'b1}));

        // Mid-frame reset on dut1 at (7,3).
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (h_1 == 10'd7 && v_1 == 10'd3) found = 1'b1;
            else wait_neg();
        end
        checkOutput("reach_7_3", 64'(found), 64'd1);
        applyStimulus(1'b0, 1);
        checkOutput("midreset_pos", 64'({h_1, v_1}), 64'({10'd14, 10'd8}));
        checkOutput("midreset_flags", 64'({active_1, fs_1, ls_1, hs_1, vs_1, rv_1}), 64'(6'b000111));
        checkOutput("midreset_req", 64'({rx_1, ry_1}), 64'd0);
        applyStimulus(1'b1, 1);
        checkOutput("restart_clk1", 64'({fs_1, pix_en_1}), 64'(2'b01));
        wait_neg();
        checkOutput("restart_clk2_fs", 64'({fs_1, active_1}), 64'(2'b11));
        checkOutput("restart_clk2_pos", 64'({h_1, v_1}), 64'd0);

        applyStimulus(1'b1, 300);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
